// File: rtl/am2909_seq_ctrl.sv
// Next-address controller for a cascade of Am2909 sequencer slices: decodes the
// microinstruction and condition into 2909 control pins, and owns a loop counter and stack-depth shadow.
module am2909_seq_ctrl #(
  parameter int CW = 12
) (
  input  logic          CP,
  input  logic          CLR,
  input  logic [2:0]    I,
  input  logic          CC,
  input  logic          CCEN,
  input  logic [CW-1:0] DIN,
  output logic [1:0]    S,
  output logic          FE,
  output logic          PUP,
  output logic          ZERO,
  output logic          PLE,
  output logic          MAPE,
  output logic [CW-1:0] CNT,
  output logic [2:0]    DEPTH,
  output logic          FULL,
  output logic          EMPTY,
  output logic          OVF,
  output logic          UNF
);

  typedef enum logic [2:0] {
    OP_JZ   = 3'd0,
    OP_CONT = 3'd1,
    OP_JMAP = 3'd2,
    OP_CJP  = 3'd3,
    OP_CJS  = 3'd4,
    OP_CRTN = 3'd5,
    OP_LDCT = 3'd6,
    OP_RPCT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SRC_UPC   = 2'b00,
    SRC_AR    = 2'b01,
    SRC_STACK = 2'b10,
    SRC_D     = 2'b11
  } src_e;

  localparam logic [2:0] DEPTH_MAX = 3'd4;

  op_e           op;
  logic          pass;
  logic          cnt_nz;
  logic          push;
  logic          pop;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [2:0]    depth_d, depth_q;
  logic          ovf_d, ovf_q;
  logic          unf_d, unf_q;

  assign op     = op_e'(I);
  assign pass   = CCEN | CC;
  assign cnt_nz = (cnt_q != '0);
  assign push   = (op == OP_CJS)  && pass;
  assign pop    = (op == OP_CRTN) && pass;

  assign FULL  = (depth_q == DEPTH_MAX);
  assign EMPTY = (depth_q == 3'd0);

  // Control pins to the 2909 slices; reset forces Y=0 with no stack activity.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    S    = SRC_UPC;
    FE   = 1'b1;
    PUP  = 1'b1;
    ZERO = 1'b1;
    PLE  = 1'b1;
    MAPE = 1'b1;
    if (!CLR) begin
      ZERO = 1'b0;
    end else begin
      case (op)
        OP_JZ:   ZERO = 1'b0;
        OP_JMAP: begin
          S    = SRC_D;
          MAPE = 1'b0;
        end
        OP_CJP: if (pass) begin
          S   = SRC_D;
          PLE = 1'b0;
        end
        OP_CJS: if (pass) begin
          S   = SRC_D;
          PLE = 1'b0;
          FE  = 1'b0;
          PUP = 1'b1;
        end
        OP_CRTN: if (pass) begin
          S   = SRC_STACK;
          FE  = 1'b0;
          PUP = 1'b0;
        end
        OP_RPCT: if (cnt_nz) begin
          S   = SRC_D;
          PLE = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The 2909 stack still performs an overflowing push or underflowing pop;
  // the shadow depth saturates and the sticky flag records the event.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (op == OP_JZ) begin
      depth_d = 3'd0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push) begin
      if (FULL) ovf_d   = 1'b1;
      else      depth_d = depth_q + 3'd1;
    end else if (pop) begin
      if (EMPTY) unf_d   = 1'b1;
      else       depth_d = depth_q - 3'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (op == OP_LDCT)
      cnt_d = DIN;
    else if (op == OP_RPCT && cnt_nz)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CP or negedge CLR) begin
    if (!CLR) begin
      cnt_q   <= '0;
      depth_q <= 3'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state samples pre-edge values.
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign CNT   = cnt_q;
  assign DEPTH = depth_q;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule

// File: tb/tb_am2909_seq_ctrl.sv
// Self-checking bench for am2909_seq_ctrl: scripted vector table, async-reset
// corner sequences, and randomized traffic against a behavioural model.
module tb_am2909_seq_ctrl;

  localparam int CW = 12;

  // Control word packing: {S[1:0], FE, PUP, ZERO, PLE, MAPE}
  localparam logic [6:0] C_DEF  = 7'b00_1_1_1_1_1;
  localparam logic [6:0] C_JZ   = 7'b00_1_1_0_1_1;
  localparam logic [6:0] C_JMAP = 7'b11_1_1_1_1_0;
  localparam logic [6:0] C_CJP  = 7'b11_1_1_1_0_1;
  localparam logic [6:0] C_CJS  = 7'b11_0_1_1_0_1;
  localparam logic [6:0] C_CRTN = 7'b10_0_0_1_1_1;
  localparam logic [6:0] C_RST  = 7'b00_1_1_0_1_1;

  logic          cp, clr, cc, ccen;
  logic [2:0]    i_op;
  logic [CW-1:0] din;
  logic [1:0]    s;
  logic          fe, pup, zero, ple, mape, full, empty, ovf, unf;
  logic [CW-1:0] cnt;
  logic [2:0]    depth;

  am2909_seq_ctrl #(.CW(CW)) dut (
    .CP(cp), .CLR(clr), .I(i_op), .CC(cc), .CCEN(ccen), .DIN(din),
    .S(s), .FE(fe), .PUP(pup), .ZERO(zero), .PLE(ple), .MAPE(mape),
    .CNT(cnt), .DEPTH(depth), .FULL(full), .EMPTY(empty), .OVF(ovf), .UNF(unf)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {s, fe, pup, zero, ple, mape};
  endfunction

  typedef struct {
    logic [2:0]    i;
    logic          cc;
    logic          ccen;
    logic [CW-1:0] din;
    logic [6:0]    exp_ctl;
    logic [CW-1:0] exp_cnt;
    logic [2:0]    exp_depth;
    logic [3:0]    exp_flags;  // {FULL, EMPTY, OVF, UNF} after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] i, logic c, logic ce, logic [CW-1:0] d,
                              logic [6:0] ec, logic [CW-1:0] en, logic [2:0] ed,
                              logic [3:0] ef);
    vec_t v;
    v.i = i; v.cc = c; v.ccen = ce; v.din = d;
    v.exp_ctl = ec; v.exp_cnt = en; v.exp_depth = ed; v.exp_flags = ef;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input vec_t v, input string tag);
    i_op = v.i; cc = v.cc; ccen = v.ccen; din = v.din;
    @(negedge cp);
    check({tag, ".ctl"}, 32'(ctl()), 32'(v.exp_ctl));
    @(posedge cp);
    #1;
    check({tag, ".cnt"}, 32'(cnt), 32'(v.exp_cnt));
    check({tag, ".depth"}, 32'(depth), 32'(v.exp_depth));
    check({tag, ".flags"}, 32'({full, empty, ovf, unf}), 32'(v.exp_flags));
  endtask

  // Behavioural reference: control pins straight from the opcode rules.
  function automatic logic [6:0] model_ctl(int op, bit pass, int mcnt);
    case (op)
      0:       return C_JZ;
      2:       return C_JMAP;
      3:       return pass ? C_CJP : C_DEF;
      4:       return pass ? C_CJS : C_DEF;
      5:       return pass ? C_CRTN : C_DEF;
      7:       return (mcnt != 0) ? C_CJP : C_DEF;
      default: return C_DEF;
    endcase
  endfunction

  initial begin
    int  m_cnt, m_depth;
    bit  m_ovf, m_unf, pass;
    int  op;

    // Reset asserted with a CJS-pass opcode present
    clr = 1'b0; i_op = 3'd4; cc = 1'b1; ccen = 1'b0; din = '0;
    #3;
    check("rst.ctl", 32'(ctl()), 32'(C_RST));
    check("rst.cnt", 32'(cnt), 0);
    check("rst.depth", 32'(depth), 0);
    check("rst.flags", 32'({full, empty, ovf, unf}), 32'(4'b0100));
    @(posedge cp);
    #1;
    check("rst.hold_depth", 32'(depth), 0);
    i_op = 3'd1;
    clr  = 1'b1;

    tbl.push_back(mk(3'd1, 0, 0, 0, C_DEF, 0, 0, 4'b0100));       // CONT
    tbl.push_back(mk(3'd3, 0, 0, 0, C_DEF, 0, 0, 4'b0100));       // CJP fail
    tbl.push_back(mk(3'd3, 1, 0, 0, C_CJP, 0, 0, 4'b0100));       // CJP cc
    tbl.push_back(mk(3'd3, 0, 1, 0, C_CJP, 0, 0, 4'b0100));       // CJP forced
    tbl.push_back(mk(3'd4, 1, 0, 0, C_CJS, 0, 1, 4'b0000));
    tbl.push_back(mk(3'd4, 1, 0, 0, C_CJS, 0, 2, 4'b0000));
    tbl.push_back(mk(3'd4, 1, 0, 0, C_CJS, 0, 3, 4'b0000));
    tbl.push_back(mk(3'd4, 1, 0, 0, C_CJS, 0, 4, 4'b1000));
    tbl.push_back(mk(3'd4, 1, 0, 0, C_CJS, 0, 4, 4'b1010));       // push on full
    tbl.push_back(mk(3'd4, 0, 0, 0, C_DEF, 0, 4, 4'b1010));       // CJS fail
    tbl.push_back(mk(3'd5, 1, 0, 0, C_CRTN, 0, 3, 4'b0010));
    tbl.push_back(mk(3'd5, 1, 0, 0, C_CRTN, 0, 2, 4'b0010));
    tbl.push_back(mk(3'd5, 1, 0, 0, C_CRTN, 0, 1, 4'b0010));
    tbl.push_back(mk(3'd5, 1, 0, 0, C_CRTN, 0, 0, 4'b0110));
    tbl.push_back(mk(3'd5, 1, 0, 0, C_CRTN, 0, 0, 4'b0111));      // pop on empty
    tbl.push_back(mk(3'd5, 0, 0, 0, C_DEF, 0, 0, 4'b0111));       // CRTN fail
    tbl.push_back(mk(3'd0, 0, 0, 0, C_JZ, 0, 0, 4'b0100));        // JZ clears flags
    tbl.push_back(mk(3'd6, 0, 0, 3, C_DEF, 3, 0, 4'b0100));       // LDCT 3
    tbl.push_back(mk(3'd7, 0, 0, 0, C_CJP, 2, 0, 4'b0100));       // RPCT ignores pass
    tbl.push_back(mk(3'd7, 0, 0, 0, C_CJP, 1, 0, 4'b0100));
    tbl.push_back(mk(3'd7, 0, 0, 0, C_CJP, 0, 0, 4'b0100));
    tbl.push_back(mk(3'd7, 1, 0, 0, C_DEF, 0, 0, 4'b0100));       // CNT holds 0
    tbl.push_back(mk(3'd2, 0, 0, 0, C_JMAP, 0, 0, 4'b0100));      // JMAP
    tbl.push_back(mk(3'd6, 0, 0, 12'hFFF, C_DEF, 12'hFFF, 0, 4'b0100));
    tbl.push_back(mk(3'd7, 1, 1, 0, C_CJP, 12'hFFE, 0, 4'b0100));
    tbl.push_back(mk(3'd2, 1, 0, 0, C_JMAP, 12'hFFE, 0, 4'b0100));

    foreach (tbl[k]) step(tbl[k], $sformatf("vec%0d", k));

    // Build DEPTH=2, CNT=5 then abort a pending push with a short CLR pulse
    step(mk(3'd6, 0, 0, 5, C_DEF, 5, 0, 4'b0100), "pre.ldct");
    step(mk(3'd4, 1, 0, 0, C_CJS, 5, 1, 4'b0000), "pre.cjs1");
    step(mk(3'd4, 1, 0, 0, C_CJS, 5, 2, 4'b0000), "pre.cjs2");
    i_op = 3'd4; cc = 1'b1; ccen = 1'b0;
    #1;
    clr = 1'b0;
    #1;
    check("arst.ctl", 32'(ctl()), 32'(C_RST));
    check("arst.depth", 32'(depth), 0);
    check("arst.cnt", 32'(cnt), 0);
    #2;
    clr  = 1'b1;
    i_op = 3'd1;
    @(posedge cp);
    #1;
    check("arst.post_depth", 32'(depth), 0);
    check("arst.post_cnt", 32'(cnt), 0);

    // CLR held low across an edge with a CJS pass present
    i_op = 3'd4; cc = 1'b1;
    clr  = 1'b0;
    @(posedge cp);
    #1;
    check("arst_edge.depth", 32'(depth), 0);
    check("arst_edge.ctl", 32'(ctl()), 32'(C_RST));
    i_op = 3'd1;
    clr  = 1'b1;

    // Randomized traffic against the behavioural model
    m_cnt = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 400; n++) begin
      op   = int'($urandom_range(0, 7));
      i_op = 3'(op);
      cc   = 1'($urandom);
      ccen = 1'($urandom);
      din  = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 6));
      pass = ccen | cc;
      @(negedge cp);
      check("rnd.ctl", 32'(ctl()), 32'(model_ctl(op, pass, m_cnt)));
      check("rnd.d_sel", (s == 2'b11) ? 32'(ple ^ mape) : 32'(ple & mape), 1);
      case (op)
        0: begin m_depth = 0; m_ovf = 0; m_unf = 0; end
        4: if (pass) begin
             if (m_depth == 4) m_ovf = 1; else m_depth++;
           end
        5: if (pass) begin
             if (m_depth == 0) m_unf = 1; else m_depth--;
           end
        6: m_cnt = int'(din);
        7: if (m_cnt > 0) m_cnt--;
        default: ;
      endcase
      @(posedge cp);
      #1;
      check("rnd.cnt", 32'(cnt), 32'(m_cnt));
      check("rnd.depth", 32'(depth), 32'(m_depth));
      check("rnd.flags", 32'({full, empty, ovf, unf}),
            32'({m_depth == 4, m_depth == 0, m_ovf, m_unf}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
